pwm_multi_channel: RTL



---
 rtl/pwm_multi_channel.sv | 115 +++++++++++
 1 files changed

// File: rtl/pwm_multi_channel.sv
// Multi-channel PWM generator: shared period counter (edge or center aligned), per-channel shadowed duty.
// Latency: pwm_out/period_end registered, one cycle after the counter state they reflect.
// Backpressure: none; writes are accepted every cycle, and duty/period/mode changes apply only at period boundaries.
module pwm_multi_channel #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int AW       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                wr_en,
    input  logic [AW-1:0]       wr_addr,
    input  logic [WIDTH-1:0]    wr_data,
    input  logic [WIDTH-1:0]    period_in,
    input  logic                center_mode,
    input  logic [CHANNELS-1:0] ch_en,
    output logic [CHANNELS-1:0] pwm_out,
    output logic                period_end
);

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_t;

    localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);
    localparam logic [WIDTH-1:0] P_RESET = '1;

    logic [WIDTH-1:0]    r_cnt;
    logic [WIDTH-1:0]    w_cnt_nxt;
    dir_t                r_dir;
    dir_t                w_dir_nxt;
    logic [WIDTH-1:0]    r_p_act;
    logic                r_mode_act;
    logic                w_bnd;
    logic [WIDTH-1:0]    r_duty_shadow [CHANNELS];
    logic [WIDTH-1:0]    r_duty_act    [CHANNELS];
    logic [CHANNELS-1:0] w_wr_hit;
    logic [CHANNELS-1:0] w_cmp;

    // Boundary = last counter value of the current period; the counter restarts from 0/up after it.
    always_comb begin
        w_bnd     = 1'b0;
        w_cnt_nxt = r_cnt;
        w_dir_nxt = r_dir;
        if (r_p_act == '0) begin
            w_bnd = 1'b1;
        end else if (!r_mode_act) begin
            w_bnd = (r_cnt == r_p_act);
        end else if (r_p_act == CNT_ONE) begin
            w_bnd = (r_cnt == CNT_ONE);
        end else begin
            w_bnd = (r_dir == DIR_DOWN) && (r_cnt == CNT_ONE);
        end

        if (w_bnd) begin
            w_cnt_nxt = '0;
            w_dir_nxt = DIR_UP;
        end else if (r_mode_act && (r_dir == DIR_DOWN)) begin
            w_cnt_nxt = r_cnt - CNT_ONE;
        end else if (r_mode_act && (r_cnt == r_p_act)) begin
            w_cnt_nxt = r_cnt - CNT_ONE;
            w_dir_nxt = DIR_DOWN;
        end else begin
            w_cnt_nxt = r_cnt + CNT_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt      <= '0;
            r_dir      <= DIR_UP;
            r_p_act    <= P_RESET;
            r_mode_act <= 1'b0;
            period_end <= 1'b0;
        end else begin
            r_cnt      <= w_cnt_nxt;
            r_dir      <= w_dir_nxt;
            period_end <= w_bnd;
            if (w_bnd) begin
                r_p_act    <= period_in;
                r_mode_act <= center_mode;
            end
        end
    end

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        // Out-of-range addresses match no channel and are dropped here.
        assign w_wr_hit[c] = wr_en && (int'(wr_addr) == c);
        assign w_cmp[c]    = (r_cnt < r_duty_act[c]);

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_duty_shadow[c] <= '0;
                r_duty_act[c]    <= '0;
            end else begin
                if (w_wr_hit[c]) begin
                    r_duty_shadow[c] <= wr_data;
                end
                if (w_bnd) begin
                    r_duty_act[c] <= w_wr_hit[c] ? wr_data : r_duty_shadow[c];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_out <= '0;
        end else begin
            pwm_out <= ch_en & w_cmp;
        end
    end

endmodule
